// File: rtl/res_ctrl_pkg.sv
// Shared types and helpers for the resilient stage controller and its counters.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package res_ctrl_pkg;

    // Controller states; IDLE is the only non-busy state.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CAPT  = 3'd1,
        ST_SAMP  = 3'd2,
        ST_CHK   = 3'd3,
        ST_REC   = 3'd4,
        ST_RECAP = 3'd5,
        ST_DRAIN = 3'd6
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the longer of the recovery wait and the sample window.
    function automatic int unsigned tmr_width(input int unsigned d1, input int unsigned samp);
        return $clog2(max_u(d1, samp) + 1);
    endfunction

    // Timer width sized for the largest legal D1 (255) and SAMPLE_CYC (15), so a
    // single package serves every legal instance configuration.
    localparam int unsigned TMR_W = tmr_width(255, 15);

    // Increment that sticks at maxv instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/res_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
// Latency: count visible one cycle after the enable is sampled.
// Backpressure: none; one increment per enabled cycle.
// Ports: clk_i, rst_ni (async active-low), en_i (increment), cnt_o (registered count).
module res_sat_counter
    import res_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] MAX_V = '1;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = WIDTH'(sat_inc(32'(cnt_q), 32'(MAX_V)));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/resilient_stage_ctrl.sv
// Synchronous token controller for one bundled-data stage with timing-error recovery.
// Latency: l_req to r_req is SAMPLE_CYC+3 cycles clean, SAMPLE_CYC+4+D0/D1 on an error.
// Backpressure: four-phase req/ack on both sides; a new token waits for r_ack low.
// Ports: clk, rst (async active-low); l_req/l_ack left handshake; r_req/r_ack right
//        handshake; err0/err1 per-lane short/long-delay flags; cap_en main-latch
//        pulse; sample shadow window; busy; err0_cnt/err1_cnt recovery counts.
// Option: define ERR_STATS_EN to build the recovery counters; otherwise they read 0.
module resilient_stage_ctrl
    import res_ctrl_pkg::*;
#(
    parameter int NLANE      = 4,
    parameter int SAMPLE_CYC = 2,
    parameter int D0         = 3,
    parameter int D1         = 15,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l_req,
    output logic             l_ack,
    output logic             r_req,
    input  logic             r_ack,
    input  logic [NLANE-1:0] err0,
    input  logic [NLANE-1:0] err1,
    output logic             cap_en,
    output logic             sample,
    output logic             busy,
    output logic [CNT_W-1:0] err0_cnt,
    output logic [CNT_W-1:0] err1_cnt
);

    localparam logic [TMR_W-1:0] SAMP_T = TMR_W'(SAMPLE_CYC);
    localparam logic [TMR_W-1:0] D0_T   = TMR_W'(D0);
    localparam logic [TMR_W-1:0] D1_T   = TMR_W'(D1);
    localparam logic [TMR_W-1:0] ONE_T  = TMR_W'(1);

    state_e           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic             l_ack_q;
    logic             r_req_q;
    logic             cap_en_q;
    logic             sample_q;
    logic             busy_q;

    logic any_err0;
    logic any_err1;

    assign any_err0 = |err0;
    assign any_err1 = |err1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            l_ack_q  <= 1'b0;
            r_req_q  <= 1'b0;
            cap_en_q <= 1'b0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // Pulses default low; each state re-asserts what it needs.
            cap_en_q <= 1'b0;
            sample_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (l_req && !r_ack && !l_ack_q) begin
                        state_q  <= ST_CAPT;
                        cap_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_CAPT: begin
                    state_q  <= ST_SAMP;
                    sample_q <= 1'b1;
                    tmr_q    <= SAMP_T;
                end
                ST_SAMP: begin
                    // tmr_q counts the window cycles still to be shown, this one included.
                    if (tmr_q == ONE_T) begin
                        state_q <= ST_CHK;
                        tmr_q   <= '0;
                    end else begin
                        sample_q <= 1'b1;
                        tmr_q    <= tmr_q - ONE_T;
                    end
                end
                ST_CHK: begin
                    // Long-delay errors need the longer wait, so they take priority.
                    if (any_err1) begin
                        state_q <= ST_REC;
                        tmr_q   <= D1_T;
                    end else if (any_err0) begin
                        state_q <= ST_REC;
                        tmr_q   <= D0_T;
                    end else begin
                        state_q <= ST_DRAIN;
                        l_ack_q <= 1'b1;
                        r_req_q <= 1'b1;
                    end
                end
                ST_REC: begin
                    // Leave on the cycle the decrement would reach zero, giving exactly
                    // D0/D1 cycles in REC.
                    if (tmr_q == ONE_T) begin
                        state_q  <= ST_RECAP;
                        cap_en_q <= 1'b1;
                        tmr_q    <= '0;
                    end else begin
                        tmr_q <= tmr_q - ONE_T;
                    end
                end
                ST_RECAP: begin
                    state_q <= ST_DRAIN;
                    l_ack_q <= 1'b1;
                    r_req_q <= 1'b1;
                end
                ST_DRAIN: begin
                    // Each side retires on its own; both may fall on the same edge.
                    if (l_ack_q && !l_req) begin
                        l_ack_q <= 1'b0;
                    end
                    if (r_req_q && r_ack) begin
                        r_req_q <= 1'b0;
                    end
                    if (!l_ack_q && !r_req_q && !r_ack) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tmr_q   <= '0;
                    l_ack_q <= 1'b0;
                    r_req_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign l_ack  = l_ack_q;
    assign r_req  = r_req_q;
    assign cap_en = cap_en_q;
    assign sample = sample_q;
    assign busy   = busy_q;

`ifdef ERR_STATS_EN
    logic cnt0_en;
    logic cnt1_en;

    // A simultaneous err0/err1 is a class-1 recovery only.
    assign cnt1_en = (state_q == ST_CHK) && any_err1;
    assign cnt0_en = (state_q == ST_CHK) && !any_err1 && any_err0;

    res_sat_counter #(.WIDTH(CNT_W)) u_cnt0 (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (cnt0_en),
        .cnt_o  (err0_cnt)
    );

    res_sat_counter #(.WIDTH(CNT_W)) u_cnt1 (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (cnt1_en),
        .cnt_o  (err1_cnt)
    );
`else
    assign err0_cnt = '0;
    assign err1_cnt = '0;
`endif

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// Scoreboard bench for resilient_stage_ctrl with randomized transactions.
// Latency: n/a.
// Backpressure: the bench drives both handshakes with random retire delays.
module tb_resilient_stage_ctrl;

    localparam int NLANE = 4;
    localparam int SC    = 2;
    localparam int D0    = 3;
    localparam int D1    = 15;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             l_req;
    logic             l_ack;
    logic             r_req;
    logic             r_ack;
    logic [NLANE-1:0] err0;
    logic [NLANE-1:0] err1;
    logic             cap_en;
    logic             sample;
    logic             busy;
    logic [CNT_W-1:0] err0_cnt;
    logic [CNT_W-1:0] err1_cnt;

    resilient_stage_ctrl #(
        .NLANE(NLANE), .SAMPLE_CYC(SC), .D0(D0), .D1(D1), .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .l_req    (l_req),
        .l_ack    (l_ack),
        .r_req    (r_req),
        .r_ack    (r_ack),
        .err0     (err0),
        .err1     (err1),
        .cap_en   (cap_en),
        .sample   (sample),
        .busy     (busy),
        .err0_cnt (err0_cnt),
        .err1_cnt (err1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lat;
        int ncap;
        int nsamp;
        int c0;
        int c1;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   m_c0     = 0;
    int   m_c1     = 0;

    task automatic check(input string name, input int act, input int expv);
        chk_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    function automatic logic [NLANE-1:0] rnd_lanes();
        return NLANE'($urandom);
    endfunction

    function automatic logic [NLANE-1:0] rnd_nonzero();
        return NLANE'($urandom_range(1, (1 << NLANE) - 1));
    endfunction

    // One token through the stage. e0v/e1v are presented only in the CHK cycle,
    // which the model places SAMPLE_CYC+2 edges after l_req is first sampled.
    // noise: 0 quiet, 1 random flags elsewhere, 2 err1 all-ones during the window.
    task automatic run_txn(input logic [NLANE-1:0] e0v, input logic [NLANE-1:0] e1v,
                           input int noise, input bit early, input bit rel_rst);
        exp_t ex;
        bit   got;
        int   dl;
        int   dr;
        ex.nsamp = SC;
        if (|e1v) begin
            ex.lat  = SC + 4 + D1;
            ex.ncap = 2;
`ifdef ERR_STATS_EN
            m_c1 = (m_c1 < CMAX) ? m_c1 + 1 : CMAX;
`endif
        end else if (|e0v) begin
            ex.lat  = SC + 4 + D0;
            ex.ncap = 2;
`ifdef ERR_STATS_EN
            m_c0 = (m_c0 < CMAX) ? m_c0 + 1 : CMAX;
`endif
        end else begin
            ex.lat  = SC + 3;
            ex.ncap = 1;
        end
        ex.c0 = m_c0;
        ex.c1 = m_c1;
        exp_q.push_back(ex);

        @(negedge clk);
        l_req = 1'b1;
        if (rel_rst) rst = 1'b1;
        got = 1'b0;
        for (int j = 0; j < 40 && !got; j++) begin
            if (j == SC + 2) begin
                err0 = e0v;
                err1 = e1v;
            end else if (noise == 1) begin
                err0 = rnd_lanes();
                err1 = rnd_lanes();
            end else if (noise == 2 && j >= 2 && j <= SC + 1) begin
                err0 = '0;
                err1 = '1;
            end else begin
                err0 = '0;
                err1 = '0;
            end
            if (early && j == 2) l_req = 1'b0;
            @(posedge clk);
            #1;
            if (rel_rst && j == 0) check("cap_after_reset_release", int'(cap_en), 1);
            if (l_ack) got = 1'b1;
            else @(negedge clk);
        end
        check("l_ack_within_bound", int'(got), 1);

        dl  = $urandom_range(0, 3);
        dr  = $urandom_range(0, 3);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (k == dl) l_req = 1'b0;
            if (k == dr) r_ack = 1'b1;
            err0 = (noise == 1) ? rnd_lanes() : '0;
            err1 = (noise == 1) ? rnd_lanes() : '0;
            @(posedge clk);
            #1;
            if (k >= dl && k >= dr && !l_ack && !r_req) got = 1'b1;
        end
        check("drain_within_bound", int'(got), 1);

        @(negedge clk);
        r_ack = 1'b0;
        err0  = '0;
        err1  = '0;
        got   = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk);
            #1;
            if (!busy) got = 1'b1;
        end
        check("idle_return_busy", int'(busy), 0);
    endtask

    // Monitor: inputs are captured at the edge the DUT samples them, outputs 1 time
    // unit later. On each r_req rise the oldest expectation is popped and compared.
    initial begin
        bit   in_txn = 1'b0;
        bit   p_lack = 1'b0;
        bit   p_rreq = 1'b0;
        int   cyc    = 0;
        int   start  = 0;
        int   ncap   = 0;
        int   nsamp  = 0;
        logic li;
        logic ra;
        exp_t ex;
        forever begin
            @(posedge clk);
            li = l_req;
            ra = r_ack;
            #1;
            if (!rst) begin
                in_txn = 1'b0;
                p_lack = 1'b0;
                p_rreq = 1'b0;
                continue;
            end
            cyc++;
            if (cap_en && !in_txn) begin
                in_txn = 1'b1;
                start  = cyc;
                ncap   = 0;
                nsamp  = 0;
            end
            if (in_txn) begin
                ncap  += int'(cap_en);
                nsamp += int'(sample);
            end
            // Retire rules: l_ack follows the sampled l_req, r_req drops on r_ack.
            if (p_lack) check("l_ack_retire", int'(l_ack), int'(li));
            if (p_rreq) check("r_req_retire", int'(r_req), int'(!ra));
            if (r_req && !p_rreq) begin
                check("r_req_has_expectation", int'(in_txn && exp_q.size() > 0), 1);
                if (in_txn && exp_q.size() > 0) begin
                    ex = exp_q.pop_front();
                    check("latency", cyc - start + 1, ex.lat);
                    check("cap_en_pulses", ncap, ex.ncap);
                    check("sample_cycles", nsamp, ex.nsamp);
                    check("l_ack_with_r_req", int'(l_ack), 1);
                    check("err0_cnt", int'(err0_cnt), ex.c0);
                    check("err1_cnt", int'(err1_cnt), ex.c1);
                end
                in_txn = 1'b0;
            end
            p_lack = l_ack;
            p_rreq = r_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NLANE-1:0] e0v;
        logic [NLANE-1:0] e1v;
        int               cls;
        rst   = 1'b0;
        l_req = 1'b0;
        r_ack = 1'b0;
        err0  = '0;
        err1  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              int'({l_ack, r_req, cap_en, sample, busy, err0_cnt, err1_cnt}), 0);
        @(negedge clk);
        rst = 1'b1;

        // r_ack still high: a new request must not be accepted.
        @(negedge clk);
        l_req = 1'b1;
        r_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("hold_idle_busy", int'(busy), 0);
        check("hold_idle_cap_en", int'(cap_en), 0);
        @(negedge clk);
        l_req = 1'b0;
        r_ack = 1'b0;
        repeat (2) @(negedge clk);

        run_txn('0, '0, 0, 1'b0, 1'b0);                 // clean token
        run_txn(4'b0100, '0, 0, 1'b0, 1'b0);            // err0 on lane 2
        run_txn(4'b0011, 4'b1000, 0, 1'b0, 1'b0);       // both classes: class 1 wins
        run_txn('0, '0, 2, 1'b0, 1'b0);                 // err1 only in the window
        run_txn('0, '0, 0, 1'b1, 1'b0);                 // l_req dropped before l_ack

        // Reset in the middle of a class-1 recovery.
        @(negedge clk);
        l_req = 1'b1;
        for (int j = 0; j <= SC + 2; j++) begin
            err1 = (j == SC + 2) ? 4'b0010 : '0;
            @(posedge clk);
            @(negedge clk);
        end
        err1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_abort", int'(busy), 1);
        #2;
        rst  = 1'b0;
        m_c0 = 0;
        m_c1 = 0;
        #1;
        check("abort_outputs",
              int'({l_ack, r_req, cap_en, sample, busy, err0_cnt, err1_cnt}), 0);
        repeat (2) @(posedge clk);
        run_txn('0, '0, 0, 1'b0, 1'b1);                 // release with l_req high

        for (int i = 0; i < 5; i++) run_txn(rnd_nonzero(), '0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            cls = $urandom_range(0, 2);
            e0v = (cls == 1) ? rnd_nonzero() : ((cls == 2) ? rnd_lanes() : '0);
            e1v = (cls == 2) ? rnd_nonzero() : '0;
            run_txn(e0v, e1v, $urandom_range(0, 2), 1'($urandom_range(0, 4) == 0), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/resilient_stage_ctrl.md
Name: resilient_stage_ctrl

Overview:
Synchronous, parametrised successor to the stage's asynchronous token controller. It sequences one bundled-data pipeline stage over four-phase req/ack handshakes on both sides, and generates a capture-enable pulse and a sample window for the shadow latches. It monitors per-lane two-class timing-error flags (err0 = short-delay, err1 = long-delay) and runs a programmable-latency recovery with recapture before the token is handed on. It sits between two datapath stages of a timing-resilient pipeline, one instance per stage.

Parameters:
NLANE, 4, number of monitored datapath lanes; one err0/err1 pair per lane
SAMPLE_CYC, 2, length of the sample window in cycles; legal range 1..15
D0, 3, recovery wait in cycles for a class-0 error; legal range 1..255
D1, 15, recovery wait in cycles for a class-1 error; D1 >= D0; legal range 1..255
CNT_W, 8, width of the error statistics counters

Ports:
clk  in  1  stage clock, rising edge
rst  in  1  asynchronous reset, active low
l_req  in  1  left request, four-phase
l_ack  out  1  left acknowledge
r_req  out  1  right request
r_ack  in  1  right acknowledge
err0  in  NLANE  per-lane class-0 error flag
err1  in  NLANE  per-lane class-1 error flag
cap_en  out  1  main-latch capture pulse
sample  out  1  shadow-latch sample window
busy  out  1  high in every state except IDLE
err0_cnt  out  CNT_W  saturating count of class-0 recoveries
err1_cnt  out  CNT_W  saturating count of class-1 recoveries

Behaviour:
- All outputs are registered. While rst is low: every output is 0, state is IDLE, timers are 0, counters are 0.
- States: IDLE, CAPT, SAMP, CHK, REC, RECAP, DRAIN.
- IDLE -> CAPT when l_req=1, r_ack=0 and l_ack=0. If r_ack=1, the block stays in IDLE.
- CAPT: cap_en=1 for exactly one cycle, then -> SAMP.
- SAMP: sample=1 for SAMPLE_CYC cycles, then -> CHK.
- CHK (one cycle): evaluate |err1 and |err0 from that cycle's inputs.
  - |err1 wins over |err0: load the timer with D1 and go -> REC.
  - Else |err0: load the timer with D0 and go -> REC.
  - Else -> DRAIN; l_ack and r_req rise together on entry.
- Error inputs outside the CHK cycle are ignored.
- REC: the timer decrements each cycle. When it reaches 0 -> RECAP.
- RECAP: cap_en=1 for one cycle, then -> DRAIN. There is no re-check; the recapture is correct by construction.
- Latency from the l_req rising edge being sampled to r_req=1:
  - no error: SAMPLE_CYC+3 cycles
  - class-0 error: SAMPLE_CYC+4+D0 cycles
  - class-1 error: SAMPLE_CYC+4+D1 cycles
- DRAIN: the two sides retire independently.
  - l_ack falls the cycle after l_req=0 is sampled.
  - r_req falls the cycle after r_ack=1 is sampled.
  - If both events occur in the same cycle, both outputs fall together.
  - Exit to IDLE once l_ack=0, r_req=0 and r_ack=0.
- l_req dropping before l_ack rises is a protocol violation and is ignored; the sequence completes.
- If l_req is still high on reset release, a fresh transaction starts normally.
- Asserting reset mid-transaction aborts it immediately; no partial pulse is emitted.

Optional Feature:
ERR_STATS_EN
- Defined: err0_cnt and err1_cnt increment by 1 on each CHK that selects class 0 or class 1 respectively, and saturate at 2^CNT_W-1. A simultaneous err0 and err1 counts as class 1 only.
- Undefined: no counter flops are built, the ports remain present, and both are tied to 0.

Decomposition:
- Shared package res_ctrl_pkg holds:
  - the state enum type
  - a localparam for timer width, $clog2(max(D1,SAMPLE_CYC)+1)
  - a saturating-increment function
- One natural sub-module, res_sat_counter (width parameter, enable, async active-low reset). It is instantiated twice under ERR_STATS_EN.

Test Plan:
- No errors, SAMPLE_CYC=2: raise l_req -> cap_en pulse at cycle 1, sample high in cycles 2-3, r_req=l_ack=1 at cycle 5. Drop l_req then raise r_ack in the same cycle -> both fall together one cycle later; lower r_ack -> IDLE, busy=0.
- err0[2]=1 at CHK, D0=3 -> REC for 3 cycles, second cap_en pulse, r_req at cycle 9; err0_cnt=1.
- err0 and err1 both asserted at CHK, D1=15 -> D1 path taken, r_req at cycle 21; err1_cnt=1, err0_cnt=0.
- err1 asserted only during SAMP -> ignored, no-error latency, counters unchanged.
- Reset asserted during REC -> all outputs 0 the same cycle. Release with l_req=1 -> new cap_en one cycle after release is sampled.
- With CNT_W=2, run 5 class-0 errors -> err0_cnt saturates at 3. Build without ERR_STATS_EN -> both counters read 0.
